ps2_rx_fifo: RTL
================

// Module: ps2_rx_fifo
// PURPOSE
//  Parametrised PS/2 keyboard receiver; next generation of the PS/2 front end feeding the LCD/character path.
//  Samples ps2c/ps2d in the system clock domain, filters the PS/2 clock and deframes 11-bit frames
//  (start, 8 data LSB-first, odd parity, stop). It also checks each frame, times out stalled frames,
//  optionally folds F0 break prefixes into a release flag, and buffers codes in a show-ahead FIFO with valid/ready.
// PARAMETERS
//  FILTER_LEN   8      consecutive identical samples required before filtered ps2c changes (>=2)
//  TIMEOUT_CYC  50000  clk cycles without a filtered falling edge before an in-progress frame is aborted
//  DEPTH        16     FIFO entries; power of two, >=2
//  DECODE_BREAK 1      1: F0 not stored, next code stored with m_rel=1; 0: every byte stored raw, m_rel=0
// PORTS
//  clk         in   1   system clock, all logic on rising edge
//  rst         in   1   synchronous, active-low reset
//  ps2c        in   1   PS/2 clock from keyboard, asynchronous
//  ps2d        in   1   PS/2 data from keyboard, asynchronous
//  m_ready     in   1   consumer ready; pop when m_valid && m_ready
//  m_valid     out  1   FIFO not empty
//  m_code      out  8   scan code at FIFO head (show-ahead)
//  m_rel       out  1   head entry is a key release (F0-prefixed)
//  count       out  $clog2(DEPTH+1)  current FIFO occupancy
//  parity_err  out  1   1-cycle pulse: frame dropped, parity not odd
//  frame_err   out  1   1-cycle pulse: frame dropped, stop bit 0 or timeout
//  overflow    out  1   1-cycle pulse: good code dropped, FIFO full
// BEHAVIOUR
//  Reset (rst=0 at a clk edge): FSM->IDLE; FIFO empty; count=0; m_valid=0; m_code=0; m_rel=0; all error pulses 0;
//   break_pend=0; filter state=1. A frame in progress is discarded, and nothing from it is pushed.
//  Input sync: ps2c and ps2d each pass through 2 flops. Filtered clock ps2c_f updates only after FILTER_LEN equal
//   synced samples. Falling edge fe = ps2c_f 1->0, one cycle wide. ps2d is sampled on the fe cycle.
//  FSM states IDLE, DATA, PARITY, STOP; bit counter 0..7:
//   IDLE:   on fe with ps2d=0 -> DATA, bitcnt=0. On fe with ps2d=1 -> stay IDLE (no error).
//   DATA:   on fe shift ps2d into bit[bitcnt] (LSB first). After bit 7 -> PARITY.
//   PARITY: on fe capture p -> STOP.
//   STOP:   on fe -> IDLE. If ps2d=0, pulse frame_err. Else if ^{data,p}==0, pulse parity_err. Else the frame is good.
//   Any non-IDLE state: timeout counter clears on each fe. When it reaches TIMEOUT_CYC-1 -> IDLE, pulse frame_err.
//  Good frame handling (cycle after STOP fe):
//   DECODE_BREAK=1 and data==F0: set break_pend, no push.
//   Otherwise push {break_pend,data} and clear break_pend. A frame error or parity error does not clear break_pend.
//  Latency: push on cycle N+1 after the stop-bit fe cycle N. m_valid/m_code valid on cycle N+2 if the FIFO was empty.
//  FIFO: circular, pointers wrap modulo DEPTH.
//   Push when full and no pop that cycle: entry dropped, overflow pulses, break_pend still cleared.
//   Push and pop in the same cycle when full: both occur, no overflow, count unchanged.
//   Pop when empty: ignored. Push and pop in the same cycle when empty: push only.
//  m_code/m_rel remain stable while m_valid=1 and m_ready=0.
//  At most one error pulse per frame. Pulses never overlap a push of the same frame.
// TESTING
//  1 Frame 0x1C (bits 0,0,0,1,1,1,0,0,0,0,1 start..stop), 20us PS/2 period -> m_valid=1, m_code=1C, m_rel=0,
//    count=1; pop with m_ready=1 -> m_valid=0, count=0.
//  2 Frames F0 then 1C, DECODE_BREAK=1 -> single entry m_code=1C m_rel=1, count=1;
//    with DECODE_BREAK=0 -> two entries F0 then 1C, m_rel=0.
//  3 Frame 0x1C with parity bit 1 -> parity_err pulses once, count stays 0. Next frame 0x32 -> m_code=32.
//  4 Stop ps2c after 5 data bits, hold high for >TIMEOUT_CYC cycles -> frame_err pulses once, FSM IDLE;
//    following full frame 0x1C received correctly.
//  5 DEPTH=4, m_ready=0, send 5 codes 01..05 -> count=4, overflow pulses on 5th, head=01;
//    drain -> 01,02,03,04 in order.
//  6 Assert rst=0 mid-frame (after bit 3), release, send 0x1C -> no stale entry, single entry 1C;
//    also send a 0.5us ps2c glitch (<FILTER_LEN cycles) -> no fe, no state change.

Source files
------------

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: sync + glitch filter, 11-bit deframer with parity/stop/timeout checks, break folding, show-ahead FIFO.
// Latency: code pushed the cycle after the stop-bit falling edge, visible at the FIFO head one cycle later.
// Backpressure: m_valid/m_ready pop; a good code arriving at a full FIFO without a same-cycle pop is dropped with an overflow pulse.
module ps2_rx_fifo #(
  parameter int FILTER_LEN   = 8,
  parameter int TIMEOUT_CYC  = 50000,
  parameter int DEPTH        = 16,
  parameter int DECODE_BREAK = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ps2c,
  input  logic                       ps2d,
  input  logic                       m_ready,
  output logic                       m_valid,
  output logic [7:0]                 m_code,
  output logic                       m_rel,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       parity_err,
  output logic                       frame_err,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int FW = $clog2(FILTER_LEN);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  // ---------------------------------------------------------------
  // Input synchronisers and clock glitch filter
  // ---------------------------------------------------------------
  logic [1:0]    c_sync_q, d_sync_q;
  logic          c_s, d_s;
  logic          ps2c_f_q, ps2c_f_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          fe;

  assign c_s = c_sync_q[1];
  assign d_s = d_sync_q[1];

  // Two-flop synchronisers for both asynchronous PS/2 lines (idle high).
  always_ff @(posedge clk) begin
    if (!rst) begin
      c_sync_q <= 2'b11;
      d_sync_q <= 2'b11;
    end else begin
      c_sync_q <= {c_sync_q[0], ps2c};
      d_sync_q <= {d_sync_q[0], ps2d};
    end
  end

  // Filtered clock flips only after FILTER_LEN consecutive samples disagree with it.
  always_comb begin
    ps2c_f_d = ps2c_f_q;
    fcnt_d   = '0;
    if (c_s != ps2c_f_q) begin
      if (fcnt_q == FILT_MAX) begin
        ps2c_f_d = c_s;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  // Filter state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ps2c_f_q <= 1'b1;
      fcnt_q   <= '0;
    end else begin
      ps2c_f_q <= ps2c_f_d;
      fcnt_q   <= fcnt_d;
    end
  end

  // Falling edge is flagged in the cycle the filter decides to drop, so it is exactly one cycle wide.
  assign fe = ps2c_f_q & ~ps2c_f_d;

  // ---------------------------------------------------------------
  // Frame deframer FSM
  // ---------------------------------------------------------------
  state_t        state_q, state_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    data_q, data_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          good_d, perr_d, ferr_d;
  logic          good_q, perr_q, ferr_q;

  // Next-state logic: shift bits on each filtered falling edge, judge the frame at the stop bit.
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    data_d   = data_q;
    par_d    = par_q;
    tmo_d    = '0;
    good_d   = 1'b0;
    perr_d   = 1'b0;
    ferr_d   = 1'b0;
    if (state_q != S_IDLE && !fe) begin
      tmo_d = tmo_q + 1'b1;
    end
    case (state_q)
      S_IDLE: begin
        if (fe && !d_s) begin
          state_d  = S_DATA;
          bitcnt_d = 3'd0;
        end
      end
      S_DATA: begin
        if (fe) begin
          data_d[bitcnt_q] = d_s;
          if (bitcnt_q == 3'd7) begin
            state_d = S_PARITY;
          end else begin
            bitcnt_d = bitcnt_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (fe) begin
          par_d   = d_s;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (fe) begin
          state_d = S_IDLE;
          if (!d_s) begin
            ferr_d = 1'b1;
          end else if (~^{data_q, par_q}) begin
            perr_d = 1'b1;
          end else begin
            good_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A stalled frame is abandoned; an edge arriving on the same cycle wins.
    if (state_q != S_IDLE && !fe && tmo_q == TMO_MAX) begin
      state_d = S_IDLE;
      ferr_d  = 1'b1;
      tmo_d   = '0;
    end
  end

  // FSM registers plus the one-cycle verdict pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      bitcnt_q <= 3'd0;
      data_q   <= 8'h00;
      par_q    <= 1'b0;
      tmo_q    <= '0;
      good_q   <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      data_q   <= data_d;
      par_q    <= par_d;
      tmo_q    <= tmo_d;
      good_q   <= good_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
    end
  end

  assign parity_err = perr_q;
  assign frame_err  = ferr_q;

  // ---------------------------------------------------------------
  // Break folding and FIFO
  // ---------------------------------------------------------------
  // data_q is still the judged byte in the cycle after the stop edge: the
  // next frame cannot shift a data bit in for many filter periods.
  logic          is_break, push_req, pop, full, do_push;
  logic          break_pend_q, ovf_q;
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;
  logic [8:0]    mem_q [DEPTH];

  assign is_break = (DECODE_BREAK != 0) && (data_q == 8'hF0);
  assign push_req = good_q && !is_break;
  assign full     = (count_q == FULL_CNT);
  assign pop      = m_valid && m_ready;
  assign do_push  = push_req && (!full || pop);

  // Break-pending flag: set by F0, consumed by the next good code even if it is dropped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      break_pend_q <= 1'b0;
    end else if (good_q && is_break) begin
      break_pend_q <= 1'b1;
    end else if (push_req) begin
      break_pend_q <= 1'b0;
    end
  end

  // FIFO storage; contents need no reset since the head is gated by m_valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q] <= {break_pend_q, data_q};
    end
  end

  // Pointers, occupancy and overflow pulse; pointers wrap naturally at power-of-two DEPTH.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      ovf_q <= push_req && full && !pop;
      if (do_push) wr_q <= wr_q + 1'b1;
      if (pop)     rd_q <= rd_q + 1'b1;
      case ({do_push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign overflow        = ovf_q;
  assign count           = count_q;
  assign m_valid         = (count_q != '0);
  assign {m_rel, m_code} = m_valid ? mem_q[rd_q] : 9'h000;

endmodule
